// File: rtl/gpio_bank_ctrl.sv
// Parametrised GPIO bank: per-port DOUT/DIR/IEN/IMODE/ISTAT registers, synchronised inputs,
// edge-detect interrupts with sticky write-1-to-clear status, and a registered 1-cycle read port.
module gpio_bank_ctrl #(
  parameter int NUM_PORTS = 3,
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_en,
  input  logic                       r_en,
  input  logic [ADDR_W-1:0]          add_reg,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  input  logic [NUM_PORTS*WIDTH-1:0] gpio_in,
  output logic [NUM_PORTS*WIDTH-1:0] gpio_out,
  output logic [NUM_PORTS*WIDTH-1:0] gpio_oe,
  output logic                       irq
);

  localparam int PW = ADDR_W - 3;
  localparam int NW = NUM_PORTS * WIDTH;

  logic [PW-1:0]        w_port;
  logic [2:0]           w_reg;
  logic [NUM_PORTS-1:0] w_hit;
  logic [NW-1:0]        w_set;
  logic [NW-1:0]        w_clr;
  logic [WIDTH-1:0]     w_rsel;

  logic [NW-1:0] r_dout;
  logic [NW-1:0] r_dir;
  logic [NW-1:0] r_ien;
  logic [NW-1:0] r_imode;
  logic [NW-1:0] r_istat;
  logic [NW-1:0] r_sync1;
  logic [NW-1:0] r_sync2;
  logic [NW-1:0] r_prev;

  assign w_port   = add_reg[ADDR_W-1:3];
  assign w_reg    = add_reg[2:0];
  assign gpio_out = r_dout;
  assign gpio_oe  = r_dir;

  // A port index with no matching hit bit (>= NUM_PORTS) silently ignores writes and reads as 0.
  always_comb begin
    w_hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_hit[p] = (w_port == PW'(p));
    end
  end

  always_comb begin
    w_clr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_en && w_hit[p] && (w_reg == 3'd5)) begin
        w_clr[p*WIDTH +: WIDTH] = wdata;
      end
    end
  end

  assign w_set = (~r_imode & r_sync2 & ~r_prev) | (r_imode & ~r_sync2 & r_prev);

  always_comb begin
    w_rsel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_hit[p]) begin
        case (w_reg)
          3'd0:    w_rsel = r_dout[p*WIDTH +: WIDTH];
          3'd1:    w_rsel = r_dir[p*WIDTH +: WIDTH];
          3'd2:    w_rsel = r_sync2[p*WIDTH +: WIDTH];
          3'd3:    w_rsel = r_ien[p*WIDTH +: WIDTH];
          3'd4:    w_rsel = r_imode[p*WIDTH +: WIDTH];
          3'd5:    w_rsel = r_istat[p*WIDTH +: WIDTH];
          default: w_rsel = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout  <= '0;
      r_dir   <= '0;
      r_ien   <= '0;
      r_imode <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_en && w_hit[p]) begin
          case (w_reg)
            3'd0:    r_dout[p*WIDTH +: WIDTH]  <= wdata;
            3'd1:    r_dir[p*WIDTH +: WIDTH]   <= wdata;
            3'd3:    r_ien[p*WIDTH +: WIDTH]   <= wdata;
            3'd4:    r_imode[p*WIDTH +: WIDTH] <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // A new edge in the same cycle as a W1C clear keeps the status bit set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_istat <= '0;
      irq     <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_istat <= (r_istat & ~w_clr) | w_set;
      irq     <= |(r_istat & r_ien);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= r_en;
      if (r_en) begin
        rdata <= w_rsel;
      end
    end
  end

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl: reads push expected data into a queue that a separate
// monitor process pops on every rvalid; pad and irq outputs are checked inline.
module tb_gpio_bank_ctrl;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int AW = 6;
  localparam int NW = NP * W;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          w_en    = 1'b0;
  logic          r_en    = 1'b0;
  logic [AW-1:0] add_reg = '0;
  logic [W-1:0]  wdata   = '0;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic [NW-1:0] gpio_in = '0;
  logic [NW-1:0] gpio_out;
  logic [NW-1:0] gpio_oe;
  logic          irq;

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] addr_q[$];
  int total = 0;
  int bad   = 0;

  gpio_bank_ctrl #(.NUM_PORTS(NP), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .w_en     (w_en),
    .r_en     (r_en),
    .add_reg  (add_reg),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    w_en = 1'b1; add_reg = a; wdata = d;
    tick();
    w_en = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] e);
    r_en = 1'b1; add_reg = a;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    r_en = 1'b0;
  endtask

  task automatic do_rw(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] e);
    r_en = 1'b1; w_en = 1'b1; add_reg = a; wdata = d;
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    r_en = 1'b0; w_en = 1'b0;
  endtask

  initial begin
    fork
      begin : monitor
        logic [W-1:0]  e;
        logic [AW-1:0] a;
        forever begin
          @(negedge clk);
          if (reset && rvalid) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL rvalid_unexpected: rdata=%h with no read pending", rdata);
            end else begin
              e = exp_q.pop_front();
              a = addr_q.pop_front();
              check($sformatf("rdata@%02h", a), 32'(rdata), 32'(e));
            end
          end
        end
      end
    join_none

    // Reset state
    #1;
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_oe", 32'(gpio_oe), 0);
    check("rst_out", 32'(gpio_out), 0);
    check("rst_irq", 32'(irq), 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Every port's DIR/DOUT reads 0, back-to-back
    for (int p = 0; p < NP; p++) begin
      do_read(AW'(p * 8 + 1), 8'h00);
      do_read(AW'(p * 8 + 0), 8'h00);
    end
    check("oe_after_reset", 32'(gpio_oe), 0);

    // Port1 output path
    do_write(6'h08, 8'hCF);
    check("out_p1", 32'(gpio_out[15:8]), 32'hCF);
    do_write(6'h09, 8'hFF);
    check("oe_p1", 32'(gpio_oe), 32'h00FF00);
    do_read(6'h08, 8'hCF);
    do_read(6'h09, 8'hFF);

    // Synchroniser latency on port0 DIN
    gpio_in[7:0] = 8'hAF;
    do_read(6'h02, 8'h00);
    do_read(6'h02, 8'h00);
    do_read(6'h02, 8'hAF);
    do_read(6'h05, 8'hAF);
    do_write(6'h05, 8'hFF);
    do_read(6'h05, 8'h00);
    check("irq_ien_off", 32'(irq), 0);

    // Rising-edge interrupt on port2 bit0, then W1C and falling edge
    do_write(6'h13, 8'h01);
    do_write(6'h14, 8'h00);
    gpio_in[16] = 1'b1;
    repeat (3) tick();
    check("irq_not_yet", 32'(irq), 0);
    tick();
    check("irq_rise", 32'(irq), 1);
    do_read(6'h15, 8'h01);
    do_write(6'h15, 8'h01);
    check("irq_lag_clear", 32'(irq), 1);
    tick();
    check("irq_cleared", 32'(irq), 0);
    gpio_in[16] = 1'b0;
    repeat (5) tick();
    do_read(6'h15, 8'h00);
    check("irq_fall_ignored", 32'(irq), 0);

    // W1C collides with a new rising edge: set wins
    gpio_in[16] = 1'b1;
    repeat (2) tick();
    do_write(6'h15, 8'h01);
    tick();
    check("irq_set_wins", 32'(irq), 1);
    do_read(6'h15, 8'h01);
    do_write(6'h15, 8'h01);
    tick();
    tick();
    check("irq_final_clear", 32'(irq), 0);

    // Ignored writes and zero reads: out-of-range port, reserved reg, DIN
    do_write(6'h28, 8'hAA);
    do_write(6'h0F, 8'h55);
    do_write(6'h0A, 8'h77);
    check("out_unchanged", 32'(gpio_out), 32'h00CF00);
    check("oe_unchanged", 32'(gpio_oe), 32'h00FF00);
    do_read(6'h28, 8'h00);
    do_read(6'h0F, 8'h00);
    do_read(6'h0A, 8'h00);
    do_read(6'h08, 8'hCF);

    // Read and write to the same register: read returns pre-write value
    do_rw(6'h10, 8'h3C, 8'h00);
    check("out_p2", 32'(gpio_out), 32'h3CCF00);
    do_read(6'h10, 8'h3C);
    tick();

    // Reset asserted while a read is being returned
    r_en = 1'b1; add_reg = 6'h08;
    tick();
    r_en = 1'b0;
    check("pre_rst_rvalid", 32'(rvalid), 1);
    check("pre_rst_rdata", 32'(rdata), 32'hCF);
    reset = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_rdata", 32'(rdata), 0);
    check("mid_rst_out", 32'(gpio_out), 0);
    check("mid_rst_oe", 32'(gpio_oe), 0);
    check("mid_rst_irq", 32'(irq), 0);
    tick();
    reset = 1'b1;
    tick();
    do_read(6'h09, 8'h00);
    do_read(6'h10, 8'h00);

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
Parametrised GPIO controller, the successor to the fixed 3x8-bit GPIO top. Handles NUM_PORTS ports of WIDTH bits, each with per-bit direction, an output data register, a synchronised input, and edge-detect interrupts with sticky W1C status. Register access uses separate write and read data buses with a 1-cycle registered read. Pad tri-states (per-bit inoutput cells) sit outside this block and are driven by gpio_out/gpio_oe.

Parameters:
NUM_PORTS, 3, number of GPIO ports (1..8)
WIDTH, 8, bits per port and register data width
ADDR_W, 6, address width; add_reg[2:0] selects the register, add_reg[ADDR_W-1:3] selects the port

Ports:
clk  input  1  system clock, 50 MHz nominal
reset  input  1  asynchronous active-low reset
w_en  input  1  write strobe, one access per cycle high
r_en  input  1  read strobe
add_reg  input  ADDR_W  register address {port, reg}
wdata  input  WIDTH  write data
rdata  output  WIDTH  read data, valid when rvalid=1
rvalid  output  1  read data valid, 1-cycle pulse
gpio_in  input  NUM_PORTS*WIDTH  pad inputs, port p at [p*WIDTH +: WIDTH]
gpio_out  output  NUM_PORTS*WIDTH  output data to pads
gpio_oe  output  NUM_PORTS*WIDTH  per-bit output enable, 1 = drive
irq  output  1  OR of all (status & enable), registered

Behaviour:
- Clock is clk. Reset is asynchronous and active-low: it is named reset, and asserting reset low immediately clears all state.
- Per-port registers (reg field): 0 DOUT RW; 1 DIR RW (1=output); 2 DIN RO (synchronised input); 3 IEN RW (interrupt enable); 4 IMODE RW (0=rising, 1=falling); 5 ISTAT R/W1C; 6-7 reserved.
- Reset values: DOUT, DIR, IEN, IMODE, ISTAT, sync flops, rdata, rvalid, irq = 0. gpio_oe therefore resets to 0 (all inputs), and gpio_out resets to 0.
- gpio_out = DOUT and gpio_oe = DIR, driven directly from the registers. A write is visible on the pads the cycle after the w_en edge.
- Input path: 2-flop synchroniser, then a 3rd "previous" flop for edge detection. DIN reads the 2nd-stage value, so a pad change appears in DIN 2 clocks later.
- Edge detect per bit:
  - rise = sync & ~prev; fall = ~sync & prev.
  - The ISTAT bit is set when (IMODE ? fall : rise) is true.
  - Edges are detected regardless of DIR (loopback of outputs is allowed) and regardless of IEN.
- ISTAT is sticky. Writing 1 clears a bit; writing 0 has no effect. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq is registered: irq <= |(ISTAT & IEN) across all ports. It deasserts 1 cycle after the last contributing bit is cleared or disabled.
- Writes: on a w_en rising-clock sample, the addressed register is updated. Writes to DIN, reserved registers, or port index >= NUM_PORTS are ignored.
- Reads:
  - When r_en is sampled, rdata <= selected register and rvalid <= 1 on the next cycle (latency 1).
  - Reserved or out-of-range addresses return 0 with rvalid=1.
  - rdata holds its last value when rvalid=0.
- Simultaneous r_en and w_en to the same register: the write takes effect and the read returns the pre-write value.
- Reset mid-operation: any pending rvalid is dropped, all registers clear, and the outputs tri-state (oe=0) immediately.

Test Plan:
1. Reset then read DIR/DOUT of every port -> rdata=0x00, rvalid pulses 1 cycle after each r_en; gpio_oe all 0.
2. Write port1 DOUT=0xCF, DIR=0xFF (add_reg=0x08, 0x09) -> gpio_out[15:8]=0xCF and gpio_oe[15:8]=0xFF the cycle after; read 0x08 returns 0xCF.
3. Drive gpio_in[7:0]=0xAF with DIR0=0, read port0 DIN (0x02) -> 0x00 if read within 2 cycles of the change, 0xAF from the 3rd cycle on.
4. IEN2=0x01, IMODE2=0, toggle gpio_in[16] 0->1 -> ISTAT2 bit0=1 and irq=1 within 4 clocks. Write ISTAT2=0x01 -> irq=0 next cycle. A falling edge does not set the bit.
5. Write ISTAT2=0x01 in the same cycle a new rising edge is detected on bit0 -> ISTAT2 bit0 stays 1 and irq stays 1.
6. Read/write add_reg port=5 (out of range) and reg=7 -> rdata=0x00, no register changes. Assert reset low mid-read -> rvalid=0 and all outputs 0 asynchronously.
